vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, sync, blank, pixel coordinates, frame/line pulses.
// Optional vertical-blank interrupt is built when VGA_TIMING_VBLANK_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CW         = 11
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic          h_synch,
  output logic          v_synch,
  output logic          blank,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          sof,
  output logic          eol,
  output logic          irq,
  input  logic          irq_ack
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_W  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_W  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ACT   = H_SYNC_POL[0];
  localparam logic          VS_ACT   = V_SYNC_POL[0];

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] hc_next;
  logic [CW-1:0] vc_next;
  logic          active;
  logic          hs_on;
  logic          vs_on;

  always_comb begin
    hc_next = hc + CW'(1);
    vc_next = vc;
    if (hc == H_LAST) begin
      hc_next = '0;
      vc_next = (vc == V_LAST) ? '0 : vc + CW'(1);
    end
    active = (hc < H_ACT_W) && (vc < V_ACT_W);
    hs_on  = (hc >= HS_START) && (hc < HS_END);
    vs_on  = (vc >= VS_START) && (vc < VS_END);
  end

  // Outputs are registered from the current counter position, so they trail hc/vc by one edge.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      hc      <= '0;
      vc      <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      h_synch <= ~HS_ACT;
      v_synch <= ~VS_ACT;
      blank   <= 1'b1;
      sof     <= 1'b0;
      eol     <= 1'b0;
    end else if (enable) begin
      hc      <= hc_next;
      vc      <= vc_next;
      pixel_x <= hc;
      pixel_y <= vc;
      h_synch <= hs_on ? HS_ACT : ~HS_ACT;
      v_synch <= vs_on ? VS_ACT : ~VS_ACT;
      blank   <= ~active;
      sof     <= (hc == '0) && (vc == '0);
      eol     <= (hc == H_LAST);
    end
  end

`ifdef VGA_TIMING_VBLANK_IRQ_EN
  logic vblank_start;
  assign vblank_start = (hc == '0) && (vc == V_ACT_W);

  // A new set outranks a simultaneous acknowledge so no vertical-blank event is lost.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (enable && vblank_start) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = irq_ack;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 32x19 raster, checked cycle by cycle
// against a position model derived from the raster definition.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 32
  localparam int VT = VA + VF + VS + VB;  // 19
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          irq_ack = 1'b0;
  logic          h_synch, v_synch, blank, sof, eol, irq;
  logic [CW-1:0] pixel_x, pixel_y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CW(CW)
  ) dut (
    .pixel_clock(clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .h_synch    (h_synch),
    .v_synch    (v_synch),
    .blank      (blank),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .sof        (sof),
    .eol        (eol),
    .irq        (irq),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ex = 0, ey = 0;
  bit started = 1'b0;
  logic exp_irq = 1'b0;
  int tb_cycle = 0;
  int last_sof = -1;
  int last_interval = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (model x=%0d y=%0d cycle=%0d)",
               tag, got, exp, ex, ey, tb_cycle);
    end
  endtask

  task automatic check_outputs();
    if (!started) begin
      check("rst_x", 32'(pixel_x), 0);
      check("rst_y", 32'(pixel_y), 0);
      check("rst_hsync", 32'(h_synch), 1);
      check("rst_vsync", 32'(v_synch), 1);
      check("rst_blank", 32'(blank), 1);
      check("rst_sof", 32'(sof), 0);
      check("rst_eol", 32'(eol), 0);
      check("rst_irq", 32'(irq), 0);
    end else begin
      check("pixel_x", 32'(pixel_x), 32'(ex));
      check("pixel_y", 32'(pixel_y), 32'(ey));
      check("blank", 32'(blank), (ex < HA && ey < VA) ? 0 : 1);
      check("h_synch", 32'(h_synch), (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1);
      check("v_synch", 32'(v_synch), (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1);
      check("sof", 32'(sof), (ex == 0 && ey == 0) ? 1 : 0);
      check("eol", 32'(eol), (ex == HT - 1) ? 1 : 0);
      check("irq", 32'(irq), 32'(exp_irq));
    end
  endtask

  // One enabled pixel: advance the model position and compare every output.
  task automatic advance();
    logic ack_s;
    enable = 1'b1;
    ack_s  = irq_ack;
    @(posedge clk);
    #1;
    tb_cycle++;
    if (!started) begin
      started = 1'b1;
      ex = 0;
      ey = 0;
    end else begin
      ex = ex + 1;
      if (ex == HT) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end
    end
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    if (ex == 0 && ey == VA) exp_irq = 1'b1;
    else if (ack_s) exp_irq = 1'b0;
`endif
    if (sof === 1'b1) begin
      if (last_sof >= 0) last_interval = tb_cycle - last_sof;
      last_sof = tb_cycle;
    end
    check_outputs();
  endtask

  task automatic hold_cycle();
    enable = 1'b0;
    @(posedge clk);
    #1;
    tb_cycle++;
    check_outputs();
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    tb_cycle++;
    check_outputs();
  endtask

  initial begin
    // Reset held with the clock running.
    #1;
    for (int i = 0; i < 3; i++) reset_cycle();
    $display("reset hold: x=%0d y=%0d hs=%0b vs=%0b blank=%0b", pixel_x, pixel_y, h_synch, v_synch, blank);

    reset_n = 1'b1;
    advance();
    check("first_sof", 32'(sof), 1);
    $display("first enabled cycle: x=%0d y=%0d sof=%0b", pixel_x, pixel_y, sof);

    // Full frame, then the next start-of-frame.
    for (int i = 0; i < HT * VT; i++) advance();
    check("sof_interval", 32'(last_interval), 32'(HT * VT));
    $display("frame: sof interval %0d", last_interval);

    // Freeze mid-line for 37 cycles.
    while (ex != 10) advance();
    for (int i = 0; i < 37; i++) hold_cycle();
    advance();
    check("resume_x", 32'(pixel_x), 11);
    while (!(ex == 0 && ey == 0)) advance();
    check("sof_interval_gated", 32'(last_interval), 32'(HT * VT + 37));
    $display("enable gating: x resumed, sof interval %0d", last_interval);

    // Vertical-blank interrupt: set, ack, then ack coinciding with set.
    while (!(ex == 0 && ey == VA)) advance();
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    check("irq_set", 32'(irq), 1);
`else
    check("irq_set", 32'(irq), 0);
`endif
    irq_ack = 1'b1;
    advance();
    irq_ack = 1'b0;
    check("irq_ack_clear", 32'(irq), 0);
    advance();
    while (!(ex == HT - 1 && ey == VA - 1)) advance();
    irq_ack = 1'b1;
    advance();
    irq_ack = 1'b0;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    check("irq_set_wins", 32'(irq), 1);
`else
    check("irq_set_wins", 32'(irq), 0);
`endif
    advance();
    $display("irq: set/ack/collision sequence done, irq=%0b", irq);

    // Mid-frame asynchronous reset during both sync pulses.
    while (!(ex == HA + HF + 2 && ey == VA + VF + 1)) advance();
    check("pre_reset_vsync", 32'(v_synch), 0);
    reset_n = 1'b0;
    #1;
    started = 1'b0;
    exp_irq = 1'b0;
    check_outputs();
    reset_cycle();
    reset_n = 1'b1;
    advance();
    check("restart_y", 32'(pixel_y), 0);
    while (!(ex == 0 && ey == VA + VF)) advance();
    check("vsync_after_restart", 32'(v_synch), 0);
    $display("mid-frame reset: restarted, v_synch active again at line %0d", pixel_y);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
